buzzer_seq: RTL and testbench

Memory-mapped melody sequencer that drives the buzzer peripheral through that peripheral's CPU-style write port. The CPU loads a note table, sets CTRL.start, and the sequencer issues timed period writes to the buzzer, one per note, then silences it. It sits between the CPU bus and the buzzer, so a tune plays without CPU involvement.

---
 rtl/buzzer_seq_if.sv | 15 +
 rtl/buzzer_seq.sv | 94 +++++++++
 tb/tb_buzzer_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/buzzer_seq_if.sv
// buzzer_seq_if: CPU register port plus buzzer write port of the melody sequencer
interface buzzer_seq_if;
   logic        wr;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        rd;
   logic [31:0] raddr;
   logic [31:0] rdata;
   logic        bz_wr;
   logic [31:0] bz_waddr;
   logic [31:0] bz_wdata;
   logic        busy;
   modport slave (input wr, waddr, wdata, rd, raddr, output rdata, bz_wr, bz_waddr, bz_wdata, busy);
   modport master (output wr, waddr, wdata, rd, raddr, input rdata, bz_wr, bz_waddr, bz_wdata, busy);
endinterface

// File: rtl/buzzer_seq.sv
// buzzer_seq: plays a note table by issuing timed period writes to the buzzer
module buzzer_seq #(
   parameter int          DEPTH          = 16,
   parameter int          TICK_DIV       = 50000,
   parameter logic [31:0] BZ_PERIOD_ADDR = 32'h0
) (
   input logic         clk,
   input logic         rst,
   buzzer_seq_if.slave bus
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [29:0] BASE = 30'h10;
   localparam logic [31:0] TICK = 32'(TICK_DIV);
   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, HOLD, SILENCE} state_t;
   state_t r_state, w_next;
   logic [31:0] r_tbl [DEPTH];
   logic [AW-1:0] r_idx, w_idx;
   logic [15:0] r_dur, r_per;
   logic [31:0] r_cnt, r_rdata, r_bz_waddr, r_bz_wdata, w_rdata;
   logic r_loop, r_busy, r_bz_wr;
   logic w_ctrl_wr, w_start, w_stop, w_tbl_wr, w_tbl_rd, w_note, w_pulse;
   logic [29:0] w_woff, w_roff;
   assign w_woff = bus.waddr[31:2] - BASE;
   assign w_roff = bus.raddr[31:2] - BASE;
   assign w_tbl_wr = bus.wr && bus.waddr[1:0] == 2'b0 && w_woff < 30'(DEPTH);
   assign w_tbl_rd = bus.raddr[1:0] == 2'b0 && w_roff < 30'(DEPTH);
   assign w_ctrl_wr = bus.wr && bus.waddr == 32'h0;
   assign w_stop = w_ctrl_wr && bus.wdata[1];
   assign w_start = w_ctrl_wr && bus.wdata[0] && !bus.wdata[1];
   assign w_note = r_state == ISSUE && w_next == HOLD;
   assign w_pulse = w_note || r_state == SILENCE;
   assign w_rdata = bus.raddr == 32'h0 ? {29'h0, r_loop, 1'b0, r_busy} :
                    bus.raddr == 32'h4 ? {24'h0, 8'(r_idx)} :
                    w_tbl_rd ? r_tbl[AW'(w_roff)] : 32'h0;
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   end
   // a zero duration read in LOAD is acted on in ISSUE, where it becomes a terminator
   always_comb begin
      w_next = r_state;
      w_idx = r_idx;
      if (w_stop && r_state != IDLE) w_next = r_state == SILENCE ? IDLE : SILENCE;
      else if (w_start) begin
         w_next = LOAD;
         w_idx = '0;
      end else case (r_state)
         LOAD: w_next = ISSUE;
         ISSUE: begin
            w_next = r_dur != 16'h0 ? HOLD : r_loop && r_idx != '0 ? LOAD : SILENCE;
            w_idx = r_dur == 16'h0 ? '0 : r_idx;
         end
         HOLD: if (r_cnt == 32'h0) begin
            w_next = r_idx != LAST || r_loop ? LOAD : SILENCE;
            w_idx = r_idx == LAST ? '0 : r_idx + 1'b1;
         end
         SILENCE: w_next = IDLE;
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx <= '0;
         r_dur <= 16'h0;
         r_per <= 16'h0;
         r_cnt <= 32'h0;
         r_loop <= 1'b0;
         r_busy <= 1'b0;
         r_bz_wr <= 1'b0;
         r_bz_waddr <= 32'h0;
         r_bz_wdata <= 32'h0;
         r_rdata <= 32'h0;
         for (int i = 0; i < DEPTH; i++) r_tbl[i] <= 32'h0;
      end else begin
         r_idx <= w_idx;
         if (r_state == LOAD) {r_dur, r_per} <= r_tbl[r_idx];
         r_cnt <= w_note ? 32'(r_dur) * TICK - 32'h1 :
                  r_state == HOLD && r_cnt != 32'h0 ? r_cnt - 32'h1 : r_cnt;
         r_bz_wr <= w_pulse;
         r_bz_waddr <= w_pulse ? BZ_PERIOD_ADDR : 32'h0;
         r_bz_wdata <= w_note ? {16'h0, r_per} : 32'h0;
         r_busy <= w_next != IDLE || r_state == SILENCE;
         if (w_ctrl_wr) r_loop <= bus.wdata[2];
         if (w_tbl_wr) r_tbl[AW'(w_woff)] <= bus.wdata;
         if (bus.rd) r_rdata <= w_rdata;
      end
   end
   assign bus.rdata = r_rdata;
   assign bus.bz_wr = r_bz_wr;
   assign bus.bz_waddr = r_bz_waddr;
   assign bus.bz_wdata = r_bz_wdata;
   assign bus.busy = r_busy;
endmodule

// File: tb/tb_buzzer_seq.sv
// tb_buzzer_seq: directed and random melodies checked against a note-timeline model
module tb_buzzer_seq;
   localparam int DEPTH = 16, TD = 4, MAXK = 512;
   localparam logic [31:0] BZA = 32'h24;
   logic clk = 1'b0, rst = 1'b1;
   int tests = 0, fails = 0;
   logic exp_wr [MAXK];
   logic [31:0] exp_data [MAXK];
   logic exp_busy [MAXK];
   int m_dur [DEPTH], m_per [DEPTH];
   logic m_loop;
   int last_pulse, end_k;
   logic [31:0] rv;
   buzzer_seq_if bus ();
   buzzer_seq #(.DEPTH(DEPTH), .TICK_DIV(TD), .BZ_PERIOD_ADDR(BZA)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.wr = 1'b1;
      bus.waddr = a;
      bus.wdata = d;
      @(negedge clk);
      bus.wr = 1'b0;
   endtask

   task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.rd = 1'b1;
      bus.raddr = a;
      @(negedge clk);
      bus.rd = 1'b0;
      d = bus.rdata;
   endtask

   task automatic load_table();
      for (int i = 0; i < DEPTH; i++) wr_reg(32'h40 + 32'(4 * i), {16'(m_dur[i]), 16'(m_per[i])});
   endtask

   task automatic rand_table(input int term_odds);
      for (int i = 0; i < DEPTH; i++) begin
         m_per[i] = int'($urandom_range(1, 65535));
         m_dur[i] = (term_odds > 0 && $urandom_range(0, term_odds - 1) == 0) ? 0 : int'($urandom_range(1, 3));
      end
   endtask

   // Timeline: first note sounds 2 cycles after start; each note lasts dur*TD+2 cycles;
   // a terminator costs 1 extra cycle before silence (2 before looping); busy drops 1 after silence.
   task automatic model();
      int k = 2, i = 0, sil = -1, nk;
      last_pulse = -1;
      end_k = MAXK;
      for (int j = 0; j < MAXK; j++) begin
         exp_wr[j] = 1'b0;
         exp_data[j] = 32'h0;
         exp_busy[j] = 1'b0;
      end
      while (k < MAXK) begin
         if (m_dur[i] == 0) begin
            if (m_loop && i != 0) begin
               i = 0;
               k += 2;
            end else begin
               sil = k + 1;
               end_k = k + 2;
               break;
            end
         end else begin
            exp_wr[k] = 1'b1;
            exp_data[k] = 32'(m_per[i]);
            last_pulse = k;
            nk = k + m_dur[i] * TD;
            if (i == DEPTH - 1 && !m_loop) begin
               sil = nk + 1;
               end_k = nk + 2;
               break;
            end
            i = (i + 1) % DEPTH;
            k = nk + 2;
         end
      end
      if (sil >= 0 && sil < MAXK) exp_wr[sil] = 1'b1;
      for (int j = 0; j < MAXK && j < end_k; j++) exp_busy[j] = 1'b1;
   endtask

   task automatic run_check(input int h, input int rdk, input logic [31:0] rexp);
      for (int k = 0; k <= h; k++) begin
         if (k > 0) @(negedge clk);
         bus.rd = 1'b0;
         chk($sformatf("bz_wr k=%0d", k), 32'(bus.bz_wr), 32'(exp_wr[k]));
         chk($sformatf("busy k=%0d", k), 32'(bus.busy), 32'(exp_busy[k]));
         chk($sformatf("bz_waddr k=%0d", k), bus.bz_waddr, exp_wr[k] ? BZA : 32'h0);
         if (exp_wr[k]) chk($sformatf("bz_wdata k=%0d", k), bus.bz_wdata, exp_data[k]);
         if (k == rdk) begin
            bus.rd = 1'b1;
            bus.raddr = 32'h4;
         end
         if (rdk >= 0 && k == rdk + 1) chk("status idx", bus.rdata, rexp);
      end
   endtask

   task automatic stop_check();
      bus.wr = 1'b1;
      bus.waddr = 32'h0;
      bus.wdata = 32'h6;
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         bus.wr = 1'b0;
         chk($sformatf("stop bz_wr j=%0d", j), 32'(bus.bz_wr), 32'(j == 2));
         if (j == 2) chk("stop bz_wdata", bus.bz_wdata, 32'h0);
         chk($sformatf("stop busy j=%0d", j), 32'(bus.busy), 32'(j < 3));
      end
      rd_reg(32'h0, rv);
      chk("ctrl loop readback", rv, 32'h4);
   endtask

   task automatic run_seq(input logic [31:0] ctrl, input int rdk, input logic [31:0] rexp);
      m_loop = ctrl[2];
      model();
      wr_reg(32'h0, ctrl);
      if (end_k < MAXK) run_check(end_k + 2, rdk, rexp);
      else begin
         run_check(last_pulse, -1, 32'h0);
         stop_check();
      end
   endtask

   task automatic directed_table();
      for (int i = 0; i < DEPTH; i++) begin
         m_dur[i] = 0;
         m_per[i] = 0;
      end
      m_dur[0] = 2;
      m_per[0] = 100;
      m_dur[1] = 1;
      m_per[1] = 200;
      load_table();
   endtask

   initial begin
      bus.wr = 1'b0;
      bus.rd = 1'b0;
      bus.waddr = 32'h0;
      bus.wdata = 32'h0;
      bus.raddr = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst bz_wr", 32'(bus.bz_wr), 32'h0);
      chk("rst bz_waddr", bus.bz_waddr, 32'h0);
      chk("rst bz_wdata", bus.bz_wdata, 32'h0);
      chk("rst busy", 32'(bus.busy), 32'h0);
      chk("rst rdata", bus.rdata, 32'h0);
      rst = 1'b0;
      rd_reg(32'h0, rv);
      chk("rst ctrl", rv, 32'h0);
      rd_reg(32'h4, rv);
      chk("rst status", rv, 32'h0);
      wr_reg(32'h54, 32'h0030_01F4);
      rd_reg(32'h54, rv);
      chk("entry5 read", rv, 32'h0030_01F4);
      @(negedge clk);
      chk("rdata hold", bus.rdata, 32'h0030_01F4);
      rd_reg(32'h3C, rv);
      chk("unmapped 0x3c", rv, 32'h0);
      directed_table();
      run_seq(32'h1, 14, 32'h1);
      run_seq(32'h5, -1, 32'h0);
      for (int i = 0; i < DEPTH; i++) begin
         m_dur[i] = 1;
         m_per[i] = int'($urandom_range(1, 65535));
      end
      load_table();
      run_seq(32'h1, -1, 32'h0);
      rand_table(0);
      m_dur[0] = 0;
      load_table();
      run_seq(32'h5, -1, 32'h0);
      for (int j = 0; j < MAXK; j++) begin
         exp_wr[j] = 1'b0;
         exp_busy[j] = 1'b0;
      end
      wr_reg(32'h0, 32'h3);
      run_check(6, -1, 32'h0);
      repeat (4) begin
         rand_table(5);
         load_table();
         run_seq($urandom_range(0, 1) == 1 ? 32'h5 : 32'h1, -1, 32'h0);
      end
      directed_table();
      wr_reg(32'h0, 32'h1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst bz_wr", 32'(bus.bz_wr), 32'h0);
      chk("midrst bz_waddr", bus.bz_waddr, 32'h0);
      chk("midrst bz_wdata", bus.bz_wdata, 32'h0);
      chk("midrst busy", 32'(bus.busy), 32'h0);
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk($sformatf("post rst bz_wr %0d", j), 32'(bus.bz_wr), 32'h0);
         chk($sformatf("post rst busy %0d", j), 32'(bus.busy), 32'h0);
      end
      rd_reg(32'h40, rv);
      chk("post rst entry0", rv, 32'h0);
      rd_reg(32'h0, rv);
      chk("post rst ctrl", rv, 32'h0);
      rd_reg(32'h4, rv);
      chk("post rst status", rv, 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
